dmem_init_loader: RTL

- Upstream feeder for the cached data memory's init port (init_done / init_wen / init_addr / init_data).
- Receives a little-endian byte stream with a valid/ready handshake, for example from a host link or a bench stream.
- Assembles the stream into 32-bit words and writes them to consecutive word addresses from BASE_ADDR, then raises init_done.
- Until init_done is high, the core/memory pair must not run.

---
 rtl/dmem_init_loader_if.sv | 22 ++
 rtl/dmem_init_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/dmem_init_loader_if.sv
// rtl/dmem_init_loader_if.sv - byte stream in / memory init port out bundle for dmem_init_loader
interface dmem_init_loader_if;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_ready;
    logic        i_stall;
    logic [3:0]  o_init_wen;
    logic [31:0] o_init_addr;
    logic [31:0] o_init_data;
    logic        o_init_done;
    logic        o_err;

    modport master (
        output i_valid, i_data, i_stall,
        input  o_ready, o_init_wen, o_init_addr, o_init_data, o_init_done, o_err
    );

    modport slave (
        input  i_valid, i_data, i_stall,
        output o_ready, o_init_wen, o_init_addr, o_init_data, o_init_done, o_err
    );
endinterface

// File: rtl/dmem_init_loader.sv
// rtl/dmem_init_loader.sv - assembles a little-endian byte stream into words for the dmem init port
// Optional trailing checksum word enabled by DMEM_INIT_LOADER_CKSUM_EN.
module dmem_init_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic              CLK,
    input  logic              RST_X,
    dmem_init_loader_if.slave bus
);
    typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_CKSUM, S_DONE} state_t;

`ifdef DMEM_INIT_LOADER_CKSUM_EN
    localparam state_t TAIL = S_CKSUM;
`else
    localparam state_t TAIL = S_DONE;
`endif
    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic        ready_q;
    logic        ready_nxt;
    logic        err_q;
    logic [1:0]  byte_idx;
    logic [23:0] shreg;
    logic [31:0] n_words;
    logic [31:0] word_cnt;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic        take;
    logic        last_byte;
    logic        commit;
    logic [31:0] asm_word;
`ifdef DMEM_INIT_LOADER_CKSUM_EN
    logic [31:0] cksum;
`endif

    // shreg holds the previous three bytes; the current byte completes the word
    assign asm_word  = {bus.i_data, shreg};
    assign take      = bus.i_valid & ready_q;
    assign last_byte = take & (byte_idx == 2'd3);
    assign commit    = (state == S_WRITE) & ~bus.i_stall;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state   <= S_HDR;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:   if (last_byte) state_nxt = (asm_word == 32'd0) ? TAIL : S_DATA;
            S_DATA:  if (last_byte) state_nxt = S_WRITE;
            S_WRITE: if (commit) state_nxt = (word_cnt + 32'd1 == n_words) ? TAIL : S_DATA;
            S_CKSUM: if (last_byte) state_nxt = S_DONE;
            default: state_nxt = S_DONE;
        endcase
    end

    always_comb begin
        bus.o_init_wen  = (state == S_WRITE) ? 4'hF : 4'h0;
        bus.o_init_done = (state == S_DONE);
        ready_nxt       = (state_nxt == S_HDR) || (state_nxt == S_DATA) || (state_nxt == S_CKSUM);
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            byte_idx  <= 2'd0;
            shreg     <= 24'd0;
            n_words   <= 32'd0;
            word_cnt  <= 32'd0;
            init_addr <= BASE_ADDR;
            init_data <= 32'd0;
            err_q     <= 1'b0;
`ifdef DMEM_INIT_LOADER_CKSUM_EN
            cksum     <= 32'd0;
`endif
        end else begin
            if (take) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= asm_word[31:8];
            end
            if (last_byte && state == S_HDR) begin
                if (asm_word > MAX_W) begin
                    n_words <= MAX_W;
                    err_q   <= 1'b1;
                end else begin
                    n_words <= asm_word;
                end
            end
            if (last_byte && state == S_DATA) init_data <= asm_word;
            if (commit) begin
                init_addr <= init_addr + 32'd4;
                word_cnt  <= word_cnt + 32'd1;
            end
`ifdef DMEM_INIT_LOADER_CKSUM_EN
            if (commit) cksum <= cksum + init_data;
            if (last_byte && state == S_CKSUM && asm_word != cksum) err_q <= 1'b1;
`endif
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_init_addr = init_addr;
    assign bus.o_init_data = init_data;
    assign bus.o_err       = err_q;
endmodule
